// File: rtl/pio_bank.sv
// Multi-channel parallel output bank on a simple read/write slave bus.
// Channel writes take effect only while the synchronized PLL lock is high; dropped writes are counted.
module pio_bank #(
   parameter int                NCH         = 3,
   parameter int                DATA_W      = 32,
   parameter logic [DATA_W-1:0] RESET_VALUE = '0
) (
   input  logic                          clk_clk,
   input  logic                          reset_reset,
   input  logic [$clog2(NCH+1)+1:0]      avs_address,
   input  logic                          avs_write,
   input  logic [DATA_W-1:0]             avs_writedata,
   input  logic                          avs_read,
   output logic [DATA_W-1:0]             avs_readdata,
   output logic                          avs_readdatavalid,
   input  logic                          pll_locked,
   output logic [NCH*DATA_W-1:0]         pio_export,
   output logic [NCH-1:0]                pio_strobe
);

   localparam int                ADDR_W   = $clog2(NCH+1)+2;
   localparam int                IDX_W    = ADDR_W-2;
   localparam logic [IDX_W-1:0]  STAT_IDX = IDX_W'(NCH);

   logic                  sync1_q;
   logic                  locked_s_q;
   logic [7:0]            drop_cnt_q, drop_cnt_d;
   logic                  rd_valid_q;
   logic [DATA_W-1:0]     rd_data_q, rd_data_d;
   logic [NCH*DATA_W-1:0] chan_flat;

   logic [IDX_W-1:0]      ch_idx;
   logic [1:0]            off;
   logic                  chan_hit;
   logic                  stat_hit;
   logic                  wr_acc;

   assign ch_idx   = avs_address[ADDR_W-1:2];
   assign off      = avs_address[1:0];
   assign chan_hit = (ch_idx < STAT_IDX);
   assign stat_hit = (ch_idx == STAT_IDX) && (off == 2'd0);
   assign wr_acc   = avs_write && chan_hit && locked_s_q;

   generate
      for (genvar gi = 0; gi < NCH; gi++) begin : gen_ch
         localparam logic [IDX_W-1:0] MY_IDX = IDX_W'(gi);
         logic [DATA_W-1:0] data_q, data_d;
         logic              strobe_q;
         logic              sel;

         assign sel = wr_acc && (ch_idx == MY_IDX);

         always_comb begin
            data_d = data_q;
            if (sel) begin
               case (off)
                  2'd0: data_d = avs_writedata;
                  2'd1: data_d = data_q | avs_writedata;
                  2'd2: data_d = data_q & ~avs_writedata;
                  2'd3: data_d = data_q ^ avs_writedata;
               endcase
            end
         end

         // data_d only differs from data_q on an accepted write, so this is the change pulse
         always_ff @(posedge clk_clk or posedge reset_reset) begin
            if (reset_reset) begin
               data_q   <= RESET_VALUE;
               strobe_q <= 1'b0;
            end else begin
               data_q   <= data_d;
               strobe_q <= (data_d != data_q);
            end
         end

         assign chan_flat[gi*DATA_W +: DATA_W] = data_q;
         assign pio_strobe[gi]                 = strobe_q;
      end
   endgenerate

   assign pio_export = chan_flat;

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (avs_write && stat_hit) begin
         drop_cnt_d = 8'd0;
      end else if (avs_write && chan_hit && !locked_s_q && (drop_cnt_q != 8'hFF)) begin
         drop_cnt_d = drop_cnt_q + 8'd1;
      end
   end

   // Read path samples pre-write state; unlocked channel reads return zero
   always_comb begin
      rd_data_d = '0;
      if (chan_hit && locked_s_q) begin
         for (int i = 0; i < NCH; i++) begin
            if (ch_idx == IDX_W'(i)) begin
               rd_data_d = chan_flat[i*DATA_W +: DATA_W];
            end
         end
      end else if (stat_hit) begin
         rd_data_d[15:8] = drop_cnt_q;
         rd_data_d[0]    = locked_s_q;
      end
   end

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         sync1_q    <= 1'b0;
         locked_s_q <= 1'b0;
         drop_cnt_q <= 8'd0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         sync1_q    <= pll_locked;
         locked_s_q <= sync1_q;
         drop_cnt_q <= drop_cnt_d;
         rd_valid_q <= avs_read && !avs_write;
         rd_data_q  <= (avs_read && !avs_write) ? rd_data_d : '0;
      end
   end

   assign avs_readdata      = rd_data_q;
   assign avs_readdatavalid = rd_valid_q;

endmodule

// File: tb/tb_pio_bank.sv
// Directed bench for pio_bank: register ops, strobes, lock gating, drop counter, reset behaviour.
module tb_pio_bank;

   localparam int NCH    = 3;
   localparam int DATA_W = 32;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [3:0]            avs_address;
   logic                  avs_write;
   logic [DATA_W-1:0]     avs_writedata;
   logic                  avs_read;
   logic [DATA_W-1:0]     avs_readdata;
   logic                  avs_readdatavalid;
   logic                  pll_locked;
   logic [NCH*DATA_W-1:0] pio_export;
   logic [NCH-1:0]        pio_strobe;

   int checks = 0;
   int errors = 0;

   pio_bank #(.NCH(NCH), .DATA_W(DATA_W), .RESET_VALUE('0)) dut (
      .clk_clk           (clk),
      .reset_reset       (rst),
      .avs_address       (avs_address),
      .avs_write         (avs_write),
      .avs_writedata     (avs_writedata),
      .avs_read          (avs_read),
      .avs_readdata      (avs_readdata),
      .avs_readdatavalid (avs_readdatavalid),
      .pll_locked        (pll_locked),
      .pio_export        (pio_export),
      .pio_strobe        (pio_strobe)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [3:0] a, input logic [DATA_W-1:0] d);
      avs_address   = a;
      avs_writedata = d;
      avs_write     = 1'b1;
      step(1);
      avs_write     = 1'b0;
   endtask

   task automatic rd(input logic [3:0] a);
      avs_address = a;
      avs_read    = 1'b1;
      step(1);
      avs_read    = 1'b0;
   endtask

   function automatic logic [DATA_W-1:0] ch(input int c);
      return pio_export[c*DATA_W +: DATA_W];
   endfunction

   initial begin
      rst = 1'b1; pll_locked = 1'b0;
      avs_address = '0; avs_write = 1'b0; avs_writedata = '0; avs_read = 1'b0;
      step(2);
      chk("rst_export", pio_export, 0);
      chk("rst_strobe", pio_strobe, 0);
      chk("rst_rdvalid", avs_readdatavalid, 0);
      chk("rst_rddata", avs_readdata, 0);
      $display("reset state checked");

      // Write right after release lands in the unlocked window
      pll_locked = 1'b1;
      rst = 1'b0;
      wr(4'd0, 32'h55);
      chk("early_wr_ch0", ch(0), 0);
      chk("early_wr_strobe", pio_strobe, 0);
      step(3);
      rd(4'd12);
      chk("stat_after_early", avs_readdata, 64'h101);
      chk("stat_valid", avs_readdatavalid, 1);
      wr(4'd12, 32'h0);
      rd(4'd12);
      chk("stat_cleared", avs_readdata, 64'h1);
      $display("early-write drop counted and cleared");

      // ch1 DATA / SET / CLR / TOGGLE back to back
      wr(4'd4, 32'hF0);
      chk("ch1_data", ch(1), 64'hF0);
      chk("ch1_data_stb", pio_strobe, 3'b010);
      wr(4'd5, 32'h0F);
      chk("ch1_set", ch(1), 64'hFF);
      chk("ch1_set_stb", pio_strobe, 3'b010);
      wr(4'd6, 32'h30);
      chk("ch1_clr", ch(1), 64'hCF);
      chk("ch1_clr_stb", pio_strobe, 3'b010);
      wr(4'd7, 32'h101);
      chk("ch1_tog", ch(1), 64'h1CE);
      chk("ch1_tog_stb", pio_strobe, 3'b010);
      step(1);
      chk("ch1_stb_end", pio_strobe, 0);
      $display("ch1 register ops done");

      // Same value twice strobes once
      wr(4'd8, 32'h1234);
      chk("ch2_first_stb", pio_strobe, 3'b100);
      wr(4'd8, 32'h1234);
      chk("ch2_second_nostb", pio_strobe, 0);
      chk("ch2_val", ch(2), 64'h1234);
      rd(4'd10);
      chk("ch2_rd_valid", avs_readdatavalid, 1);
      chk("ch2_rd_data", avs_readdata, 64'h1234);
      step(1);
      chk("ch2_rd_valid_drop", avs_readdatavalid, 0);
      chk("ch2_rd_data_zero", avs_readdata, 0);
      $display("ch2 identical write and read done");

      // Unlocked: 300 dropped writes saturate the counter
      pll_locked = 1'b0;
      step(3);
      for (int i = 0; i < 300; i++) wr(4'd0, 32'h77);
      chk("unlocked_ch0", ch(0), 0);
      chk("unlocked_stb", pio_strobe, 0);
      rd(4'd12);
      chk("stat_sat", avs_readdata, 64'hFF00);
      wr(4'd12, 32'h0);
      rd(4'd12);
      chk("stat_clr_unlocked", avs_readdata, 0);
      $display("drop counter saturation done");
      pll_locked = 1'b1;
      step(3);

      // Simultaneous read and write: write wins
      avs_address = 4'd0; avs_writedata = 32'hA5; avs_write = 1'b1; avs_read = 1'b1;
      step(1);
      avs_write = 1'b0; avs_read = 1'b0;
      chk("rw_ch0", ch(0), 64'hA5);
      chk("rw_novalid", avs_readdatavalid, 0);
      rd(4'd15);
      chk("unmapped_valid", avs_readdatavalid, 1);
      chk("unmapped_data", avs_readdata, 0);
      rd(4'd7);
      chk("ch1_off3_rd", avs_readdata, 64'h1CE);
      wr(4'd13, 32'hFFFF);
      rd(4'd12);
      chk("unmapped_wr_ignored", avs_readdata, 64'h1);
      $display("read/write collision and unmapped done");

      // Async reset mid-cycle with a read pending
      wr(4'd0, 32'hFFFF);
      chk("pre_rst_ch0", ch(0), 64'hFFFF);
      avs_address = 4'd0; avs_read = 1'b1;
      #3 rst = 1'b1;
      #1;
      chk("async_rst_export", pio_export, 0);
      chk("async_rst_valid", avs_readdatavalid, 0);
      avs_read = 1'b0;
      step(2);
      rst = 1'b0;
      chk("post_rel_valid0", avs_readdatavalid, 0);
      wr(4'd0, 32'h55);
      chk("post_rel_valid1", avs_readdatavalid, 0);
      chk("post_rel_ch0", ch(0), 0);
      step(3);
      rd(4'd12);
      chk("post_rel_drop", avs_readdata, 64'h101);
      $display("async reset sequence done");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pio_bank.md
PIO_BANK -- requirements
Module: pio_bank

Interface
- REQ-001 Parameter NCH, default 3: number of output channels, legal range 1..15.
- REQ-002 Parameter DATA_W, default 32: width of each channel and of the bus data, legal range 16..32.
- REQ-003 Parameter RESET_VALUE, default 0: DATA_W-bit value loaded into every channel on reset.
- REQ-004 Localparam ADDR_W = $clog2(NCH+1)+2: word address width.
- REQ-005 Port clk_clk, input, 1 bit: the only clock; all logic is rising-edge.
- REQ-006 Port reset_reset, input, 1 bit: asynchronous, active-high reset.
- REQ-007 Port avs_address, input, ADDR_W bits: word address; channel index is bits [ADDR_W-1:2], register offset is bits [1:0].
- REQ-008 Port avs_write, input, 1 bit: write request.
- REQ-009 Port avs_writedata, input, DATA_W bits: write data.
- REQ-010 Port avs_read, input, 1 bit: read request.
- REQ-011 Port avs_readdata, output, DATA_W bits: read data.
- REQ-012 Port avs_readdatavalid, output, 1 bit: qualifies avs_readdata.
- REQ-013 Port pll_locked, input, 1 bit: PLL lock indication, asynchronous to clk_clk.
- REQ-014 Port pio_export, output, NCH*DATA_W bits: channel i drives bits [i*DATA_W +: DATA_W].
- REQ-015 Port pio_strobe, output, NCH bits: per-channel change pulse.

Function
- REQ-016 pll_locked SHALL pass through a 2-flop synchronizer; the synchronized result is locked_s, which lags by 2 cycles.
- REQ-017 Channel register map for i < NCH, offsets 0–3; each access is accepted only when locked_s=1. Reads at any offset return DATA[i].
  - Offset 0, DATA: write sets DATA[i] = wd.
  - Offset 1, SET: write sets DATA[i] |= wd.
  - Offset 2, CLR: write sets DATA[i] &= ~wd.
  - Offset 3, TOGGLE: write sets DATA[i] ^= wd.
- REQ-018 Status register at channel index NCH, offset 0:
  - Read returns bit0 = locked_s, bits[15:8] = drop_cnt, all other bits 0.
  - A write clears drop_cnt to 0, regardless of locked_s.
- REQ-019 A channel-register write attempted while locked_s=0 SHALL be dropped and SHALL increment drop_cnt (8-bit, saturating at 255).
- REQ-020 Accesses to unmapped addresses: reads return 0; writes are ignored and not counted.
- REQ-021 Write latency: the new DATA[i] SHALL appear on pio_export on the clock edge that samples avs_write.
- REQ-022 Read latency is fixed at 1: avs_readdatavalid=1 and avs_readdata are valid in the cycle after avs_read; otherwise avs_readdatavalid=0 and avs_readdata=0.
- REQ-023 Read data SHALL reflect register state before any write in the same cycle.
- REQ-024 If avs_read and avs_write are asserted together, the write SHALL be performed and the read ignored (no avs_readdatavalid).
- REQ-025 pio_strobe[i] SHALL be 1 for exactly one cycle, the cycle after an accepted write that changed DATA[i].
  - A write producing an identical value SHALL NOT strobe.
  - Back-to-back changing writes SHALL give consecutive strobe cycles.
- REQ-026 The block always accepts requests and has no wait states.
- REQ-027 pio_export SHALL always equal the channel registers, independent of locked_s.

Reset
- REQ-028 On reset_reset=1, the following SHALL take effect immediately, without a clock edge:
  - every DATA[i] = RESET_VALUE;
  - drop_cnt = 0, both synchronizer flops = 0;
  - pio_strobe = 0, avs_readdatavalid = 0, avs_readdata = 0.
- REQ-029 A read or write in flight when reset asserts SHALL be discarded; no avs_readdatavalid follows reset release.
- REQ-030 After reset release, locked_s SHALL remain 0 for at least 2 cycles; writes in that window are dropped and counted.

Verification
- REQ-031 pll_locked=1, wait 3 cycles; write ch1 DATA=0x0000_00F0, SET 0x0F, CLR 0x30, TOGGLE 0x101.
  - Required: ch1 = 0xF0 → 0xFF → 0xCF → 0x1CE, each on the write edge.
  - Required: pio_strobe[1] pulses once after each write.
- REQ-032 pll_locked=0; issue 300 writes to ch0.
  - Required: ch0 stays at RESET_VALUE, status read returns drop_cnt=255, bit0=0.
  - Then write status: required status read returns 0.
- REQ-033 Write ch2 DATA=0x1234 twice.
  - Required: one pio_strobe[2] pulse only.
  - Required: read ch2 offset 2 returns 0x1234 with avs_readdatavalid exactly 1 cycle after avs_read.
- REQ-034 Assert read and write to ch0 DATA=0xA5 in the same cycle.
  - Required: ch0=0xA5, no avs_readdatavalid.
  - Read of unmapped address (NCH, offset 3) returns 0.
- REQ-035 Assert reset_reset mid-clock while ch0=0xFFFF and a read is pending.
  - Required: pio_export=RESET_VALUE immediately; no avs_readdatavalid after release.
  - Required: a write 1 cycle after release is counted in drop_cnt.
